// File: rtl/flappy_bird_control_mem_arbiter.sv
// Two-master round-robin arbiter with lock and bounded starvation in front of a
// single-port synchronous memory whose read data returns one cycle after the address.
module flappy_bird_control_mem_arbiter #(
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic                  m0_lock,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic                  m1_lock,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    logic              req0, req1;
    logic              gnt0, gnt1, gnt_any, gnt_sel;
    logic              owner_req, owner_lock, locked;
    logic              sel_write, sel_lock, other_req;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic [CNT_W-1:0]  cnt_base;

    logic              rr_last;
    logic              lock_active, lock_owner;
    logic [CNT_W-1:0]  lock_cnt;
    logic              rd_pend, rd_owner;
    logic [ADDR_W-1:0] addr_hold;
    logic [BE_W-1:0]   be_hold;
    logic [DATA_W-1:0] wdata_hold;
    logic [DATA_W-1:0] rdata0_hold, rdata1_hold;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Arbitration: same-cycle grant, lock holds the owner until the starvation bound trips.
    always_comb begin
        owner_req  = lock_owner ? req1 : req0;
        owner_lock = lock_owner ? m1_lock : m0_lock;
        locked     = lock_active & owner_req & owner_lock;
        gnt_sel    = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (reset_n) begin
            if (req0 & req1) begin
                if (locked)
                    gnt_sel = (lock_cnt >= MAX_CNT) ? ~lock_owner : lock_owner;
                else
                    gnt_sel = ~rr_last;
                gnt0 = ~gnt_sel;
                gnt1 = gnt_sel;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign sel_write = gnt1 ? m1_write      : m0_write;
    assign sel_lock  = gnt1 ? m1_lock       : m0_lock;
    assign other_req = gnt1 ? req0          : req1;
    assign sel_addr  = gnt1 ? m1_address    : m0_address;
    assign sel_be    = gnt1 ? m1_byteenable : m0_byteenable;
    assign sel_wdata = gnt1 ? m1_writedata  : m0_writedata;
    assign cnt_base  = (locked && (gnt1 == lock_owner)) ? lock_cnt : '0;

    assign m0_waitrequest = ~reset_n | (req0 & ~gnt0);
    assign m1_waitrequest = ~reset_n | (req1 & ~gnt1);

    assign mem_chipselect = gnt_any;
    assign mem_write      = gnt_any & sel_write;
    assign mem_address    = gnt_any ? sel_addr  : addr_hold;
    assign mem_byteenable = gnt_any ? sel_be    : be_hold;
    assign mem_writedata  = gnt_any ? sel_wdata : wdata_hold;
    assign mem_clken      = reset_n;

    // Read return stage: memory data arrives one cycle after the granted address.
    assign m0_readdatavalid = rd_pend & ~rd_owner;
    assign m1_readdatavalid = rd_pend &  rd_owner;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : rdata0_hold;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : rdata1_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last     <= 1'b1;
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
            lock_cnt    <= '0;
            rd_pend     <= 1'b0;
            rd_owner    <= 1'b0;
            addr_hold   <= '0;
            be_hold     <= '0;
            wdata_hold  <= '0;
            rdata0_hold <= '0;
            rdata1_hold <= '0;
        end else begin
            rd_pend <= gnt_any & ~sel_write;
            if (gnt_any) begin
                rd_owner   <= gnt1;
                rr_last    <= gnt1;
                addr_hold  <= sel_addr;
                be_hold    <= sel_be;
                wdata_hold <= sel_wdata;
            end
            if (m0_readdatavalid)
                rdata0_hold <= mem_readdata;
            if (m1_readdatavalid)
                rdata1_hold <= mem_readdata;

            // A forced hand-off keeps the lock alive so the owner resumes afterwards.
            if (gnt_any && locked && (gnt1 != lock_owner)) begin
                lock_cnt <= '0;
            end else if (gnt_any && sel_lock) begin
                lock_active <= 1'b1;
                lock_owner  <= gnt1;
                lock_cnt    <= other_req ? cnt_base + 1'b1 : cnt_base;
            end else begin
                lock_active <= 1'b0;
                lock_cnt    <= '0;
            end
        end
    end

endmodule

// File: doc/flappy_bird_control_mem_arbiter.md
FLAPPY_BIRD_CONTROL_MEM_ARBITER -- requirements
Module: flappy_bird_control_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 2, memory word-address width (4 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 The block SHALL have parameter MAX_LOCK, default 4, maximum consecutive grants to one locked master while the other master waits.
REQ-004 The port list SHALL be as follows:
- clk, input, 1: single clock; all logic is rising-edge.
- reset_n, input, 1: asynchronous active-low reset.
- mX_address (X=0,1), input, ADDR_W: master word address.
- mX_byteenable, input, DATA_W/8: write byte lanes.
- mX_read, input, 1: read request.
- mX_write, input, 1: write request.
- mX_writedata, input, DATA_W: write data.
- mX_lock, input, 1: request to hold grant across consecutive transfers.
- mX_waitrequest, output, 1: transfer not accepted this cycle.
- mX_readdata, output, DATA_W: read data.
- mX_readdatavalid, output, 1: mX_readdata valid this cycle.
- mem_address, output, ADDR_W: memory address.
- mem_byteenable, output, DATA_W/8: memory byte lanes.
- mem_chipselect, output, 1: memory select.
- mem_write, output, 1: memory write.
- mem_writedata, output, DATA_W: memory write data.
- mem_clken, output, 1: memory clock enable.
- mem_readdata, input, DATA_W: memory read data, valid 1 cycle after the address.

Function
REQ-005 mX_req SHALL be mX_read | mX_write; simultaneous read and write from one master SHALL be treated as a write.
REQ-006 Each cycle at most one master SHALL be granted, combinationally from the current requests, the rr_last register and the lock state.
REQ-007 With one master requesting, that master SHALL be granted in the same cycle (zero added latency).
REQ-008 With both masters requesting and no active lock, the master not equal to rr_last SHALL be granted.
REQ-009 rr_last SHALL update to the granted master index on every granted cycle; its reset value is 1, so master 0 wins the first tie.
REQ-010 Lock: if the granted master asserts mX_lock with its request, it SHALL keep the grant on following cycles while mX_req and mX_lock stay high.
REQ-011 lock_cnt SHALL increment on each locked grant while the other master is requesting, and clear when the lock ends.
REQ-012 When lock_cnt reaches MAX_LOCK, the other master SHALL be granted for one cycle; lock_cnt SHALL then clear.
REQ-013 mX_waitrequest SHALL equal mX_req & ~grantX; with no request it SHALL be 0.
REQ-014 For the granted master, mem_address, mem_byteenable, mem_writedata and mem_write SHALL be that master's signals, and mem_chipselect SHALL be 1.
REQ-015 With no grant, mem_chipselect and mem_write SHALL be 0 and the other memory outputs SHALL hold their last values.
REQ-016 On a granted read, rd_pend/rd_owner SHALL register it.
REQ-017 Exactly one cycle after a granted read, mOwner_readdatavalid SHALL be 1 and mOwner_readdata SHALL equal mem_readdata.
REQ-018 Non-owner readdatavalid SHALL be 0; readdata SHALL hold its last value.
REQ-019 Back-to-back reads, including alternating owners, SHALL be supported every cycle without bubbles; each read's valid returns only to its own owner.
REQ-020 A write followed next cycle by a read of the same address SHALL return the new data.
REQ-021 mem_clken SHALL be 1 whenever reset_n is high.

Reset
REQ-022 While reset_n is 0, the block SHALL drive the following regardless of inputs:
- rr_last=1, lock_cnt=0, rd_pend=0.
- both readdatavalid=0, both waitrequest=1.
- mem_chipselect=0, mem_write=0, mem_clken=0.
- readdata=0, mem_address=0.
REQ-023 Reset asserted with a read pending SHALL discard it; no readdatavalid SHALL appear after release.
REQ-024 The first cycle after reset release SHALL arbitrate normally.

Verification
REQ-025 m0 writes 0xDEADBEEF to addr 2 (byteenable 0xF), then m1 reads addr 2 -> m1_readdatavalid=1 one cycle later with 0xDEADBEEF; m0_readdatavalid stays 0.
REQ-026 Both masters read every cycle for 8 cycles from reset -> grants alternate 0,1,0,1; each waitrequest is high on alternate cycles; 4 valids per master in issue order.
REQ-027 m1 holds lock and reads for 10 cycles while m0 requests, MAX_LOCK=4 -> m1 granted 4 cycles, m0 1 cycle, repeating; m0 wait never exceeds 4 cycles.
REQ-028 Byte-lane write: m0 writes 0x11223344 with byteenable 0x3 over 0xAAAAAAAA at addr 1 -> readback 0xAAAA3344.
REQ-029 reset_n pulsed low while an m0 read is pending -> no m0_readdatavalid afterwards; next tie grants m0.
REQ-030 Idle bus for 5 cycles -> mem_chipselect=0, mem_write=0, both waitrequest=0, no readdatavalid.
